// File: rtl/u_b_update_sequencer.sv
// u/beta update sequencer: sweeps neuron groups, applies leak and input
// current per lane, thresholds, writes back potentials and emits spikes.
module u_b_update_sequencer #(
  parameter logic signed [15:0] THRESH = 16'sd1024
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [8:0]   last_addr,
  output logic         busy,
  output logic         done,
  output logic [8:0]   cntrl_potential_read_addr,
  output logic [8:0]   cntrl_beta_read_addr,
  input  logic [127:0] potential_read_in,
  input  logic [63:0]  beta_read_in,
  input  logic [127:0] cur_in,
  input  logic         cur_valid,
  output logic         cur_ready,
  output logic [8:0]   cntrl_potential_write_addr,
  output logic         cntrl_potential_write_we,
  output logic [127:0] potential_write_out,
  output logic         spike_valid,
  output logic [8:0]   spike_addr,
  output logic [7:0]   spike_out
);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_CMP, S_WB, S_DONE} state_t;

  state_t       state_q, state_d;
  logic [8:0]   idx_q, idx_d;
  logic [8:0]   last_q, last_d;
  logic [8:0]   rd_addr_q, rd_addr_d;
  logic [8:0]   wr_addr_q, wr_addr_d;
  logic         we_q, we_d;
  logic [127:0] wr_data_q, wr_data_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         spike_valid_q, spike_valid_d;
  logic [8:0]   spike_addr_q, spike_addr_d;
  logic [7:0]   spike_out_q, spike_out_d;

  logic [127:0] res_data;
  logic [7:0]   res_spike;
  logic [16:0]  lane_res;

  // Returns {fired, written value} for one lane.
  function automatic logic [16:0] lane_calc(input logic [15:0] u,
                                            input logic [7:0]  b,
                                            input logic [15:0] c);
    logic [24:0] p;
    logic [15:0] d;
    logic [16:0] s;
    logic [15:0] v;
    logic        fire;
    // Sign-extended u times zero-extended beta; the true product fits in
    // 25 signed bits, so the modular unsigned product is the exact result.
    p = {{9{u[15]}}, u} * {17'b0, b};
    d = p[23:8];
    s = {d[15], d} + {c[15], c};
    if (s[16] != s[15]) v = s[16] ? 16'h8000 : 16'h7FFF;
    else                v = s[15:0];
    fire = ($signed(v) >= THRESH);
    return {fire, fire ? 16'h0000 : v};
  endfunction

  // Per-lane leak, integrate, saturate and threshold on the current SRAM data.
  always_comb begin
    res_data  = '0;
    res_spike = '0;
    lane_res  = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      lane_res = lane_calc(potential_read_in[16*k +: 16], beta_read_in[8*k +: 8],
                           cur_in[16*k +: 16]);
      res_data[16*k +: 16] = lane_res[15:0];
      res_spike[k]         = lane_res[16];
    end
  end

  // Next-state and next-output logic for the sweep FSM.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    last_d        = last_q;
    rd_addr_d     = rd_addr_q;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    busy_d        = busy_q;
    spike_addr_d  = spike_addr_q;
    spike_out_d   = spike_out_q;
    we_d          = 1'b0;
    spike_valid_d = 1'b0;
    done_d        = 1'b0;
    cur_ready     = 1'b0;
    case (state_q)
      S_IDLE: begin
        idx_d = '0;
        if (start) begin
          last_d    = last_addr;
          rd_addr_d = '0;
          busy_d    = 1'b1;
          state_d   = S_RD;
        end
      end
      S_RD: state_d = S_CMP;
      S_CMP: begin
        if (cur_valid) begin
          cur_ready     = 1'b1;
          wr_data_d     = res_data;
          spike_out_d   = res_spike;
          wr_addr_d     = idx_q;
          spike_addr_d  = idx_q;
          we_d          = 1'b1;
          spike_valid_d = 1'b1;
          state_d       = S_WB;
        end
      end
      S_WB: begin
        if (idx_q == last_q) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          idx_d     = idx_q + 9'd1;
          rd_addr_d = idx_q + 9'd1;
          state_d   = S_RD;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      last_q        <= '0;
      rd_addr_q     <= '0;
      wr_addr_q     <= '0;
      we_q          <= 1'b0;
      wr_data_q     <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      spike_valid_q <= 1'b0;
      spike_addr_q  <= '0;
      spike_out_q   <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      last_q        <= last_d;
      rd_addr_q     <= rd_addr_d;
      wr_addr_q     <= wr_addr_d;
      we_q          <= we_d;
      wr_data_q     <= wr_data_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      spike_valid_q <= spike_valid_d;
      spike_addr_q  <= spike_addr_d;
      spike_out_q   <= spike_out_d;
    end
  end

  assign busy                       = busy_q;
  assign done                       = done_q;
  assign cntrl_potential_read_addr  = rd_addr_q;
  assign cntrl_beta_read_addr       = rd_addr_q;
  assign cntrl_potential_write_addr = wr_addr_q;
  assign cntrl_potential_write_we   = we_q;
  assign potential_write_out        = wr_data_q;
  assign spike_valid                = spike_valid_q;
  assign spike_addr                 = spike_addr_q;
  assign spike_out                  = spike_out_q;

endmodule

// File: tb/tb_u_b_update_sequencer.sv
// Directed self-checking bench for u_b_update_sequencer.
module tb_u_b_update_sequencer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [8:0]   last_addr;
  logic         busy, done;
  logic [8:0]   rd_addr, beta_addr;
  logic [127:0] potential_read_in;
  logic [63:0]  beta_read_in;
  logic [127:0] cur_in;
  logic         cur_valid, cur_ready;
  logic [8:0]   wr_addr;
  logic         we;
  logic [127:0] wr_data;
  logic         spike_valid;
  logic [8:0]   spike_addr;
  logic [7:0]   spike_out;

  logic [127:0] pmem [0:511];
  logic [63:0]  bmem [0:511];

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [127:0] EXP_G0 =
    {16'hFFF9, 16'h03FF, 16'hFFFF, 16'h0000, 16'hFE0C, 16'h8000, 16'h0000, 16'h0000};

  u_b_update_sequencer #(.THRESH(16'sd1024)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .last_addr(last_addr),
    .busy(busy), .done(done),
    .cntrl_potential_read_addr(rd_addr), .cntrl_beta_read_addr(beta_addr),
    .potential_read_in(potential_read_in), .beta_read_in(beta_read_in),
    .cur_in(cur_in), .cur_valid(cur_valid), .cur_ready(cur_ready),
    .cntrl_potential_write_addr(wr_addr), .cntrl_potential_write_we(we),
    .potential_write_out(wr_data), .spike_valid(spike_valid),
    .spike_addr(spike_addr), .spike_out(spike_out)
  );

  always #5 clk = ~clk;

  // SRAM model: data follows the registered address by one cycle.
  always @(posedge clk) begin
    potential_read_in <= pmem[rd_addr];
    beta_read_in      <= bmem[beta_addr];
  end

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int k, input logic [15:0] u, input logic [7:0] b,
                          input logic [15:0] c);
    pmem[0][16*k +: 16] = u;
    bmem[0][8*k +: 8]   = b;
    cur_in[16*k +: 16]  = c;
  endtask

  initial begin
    int busy_cnt, wr_cnt, done_cnt, seen, cyc;
    logic bad_we, bad_done;

    for (int a = 0; a < 512; a++) begin
      pmem[a] = '0;
      bmem[a] = '0;
    end
    cur_in    = '0;
    set_lane(0, 16'd1000,  8'd128, 16'd600);     // 1100 fires -> 0
    set_lane(1, 16'h7FFF,  8'd255, 16'h7FFF);    // saturates 32767, fires -> 0
    set_lane(2, 16'h8000,  8'd255, 16'h8000);    // saturates -32768
    set_lane(3, -16'sd1000, 8'd128, 16'd0);      // -500
    set_lane(4, 16'd1023,  8'd255, 16'd5);       // 1019+5 = 1024 fires
    set_lane(5, 16'hFFFF,  8'd1,   16'd0);       // -1 >>> 8 = -1
    set_lane(6, 16'd1023,  8'd255, 16'd4);       // 1023, just below threshold
    set_lane(7, 16'd100,   8'd0,   -16'sd7);     // -7

    rst_n = 1'b0; start = 1'b0; last_addr = '0; cur_valid = 1'b0;
    repeat (3) tick();
    check_val("rst_out_a", {rd_addr, beta_addr, busy, done, cur_ready, wr_addr, we,
                            spike_valid, spike_addr, spike_out}, '0);
    check_val("rst_wdata", wr_data, '0);
    rst_n = 1'b1;
    tick();

    // Single group, cur_valid already high.
    cur_valid = 1'b1; last_addr = 9'd0; start = 1'b1;
    tick(); start = 1'b0;                                   // RD
    check_val("g0_rd_busy", {busy, rd_addr, beta_addr}, {1'b1, 9'd0, 9'd0});
    check_val("g0_rd_ready", cur_ready, 0);
    tick();                                                 // CMP
    check_val("g0_cmp_ready", cur_ready, 1);
    tick();                                                 // WB
    check_val("g0_wb_ctl", {we, wr_addr, spike_valid, spike_addr, busy},
              {1'b1, 9'd0, 1'b1, 9'd0, 1'b1});
    check_val("g0_wdata", wr_data, EXP_G0);
    check_val("g0_spikes", spike_out, 8'h13);
    tick();                                                 // DONE
    check_val("g0_done", {done, busy, we, spike_valid}, 4'b1000);
    tick();
    check_val("g0_done_gone", done, 0);

    // Stall in CMP for 5 cycles.
    cur_valid = 1'b0; start = 1'b1;
    tick(); start = 1'b0;                                   // RD
    tick();                                                 // CMP
    for (int i = 0; i < 5; i++) begin
      check_val("stall_state", {cur_ready, we, spike_valid, busy, rd_addr, beta_addr},
                {1'b0, 1'b0, 1'b0, 1'b1, 9'd0, 9'd0});
      if (i < 4) tick();
    end
    tick();
    cur_valid = 1'b1; #1;
    check_val("stall_accept", cur_ready, 1);
    tick();                                                 // WB
    check_val("stall_wb", {we, wr_addr}, {1'b1, 9'd0});
    check_val("stall_wdata", wr_data, EXP_G0);
    check_val("stall_ready_wb", cur_ready, 0);
    tick();                                                 // DONE
    check_val("stall_done", {done, cur_ready}, 2'b10);
    tick();

    // Full sweep over 512 groups, stray start mid-sweep.
    last_addr = 9'd511; start = 1'b1;
    tick(); start = 1'b0;
    busy_cnt = 0; wr_cnt = 0; done_cnt = 0; seen = 0;
    for (int c = 0; c < 2000 && seen == 0; c++) begin
      if (busy) busy_cnt++;
      if (we) begin
        check_val("sweep_waddr", 128'(wr_addr), 128'(wr_cnt));
        wr_cnt++;
      end
      if (done) begin
        done_cnt++;
        seen = 1;
        check_val("sweep_busy_at_done", busy, 0);
      end
      if (c == 700) begin start = 1'b1; last_addr = 9'd3; end
      else start = 1'b0;
      tick();
    end
    check_val("sweep_done_seen", 128'(seen), 1);
    start = 1'b0;
    repeat (6) begin
      if (done) done_cnt++;
      if (we) wr_cnt++;
      tick();
    end
    check_val("sweep_writes", 128'(wr_cnt), 512);
    check_val("sweep_busy_cycles", 128'(busy_cnt), 1536);
    check_val("sweep_done_pulses", 128'(done_cnt), 1);

    // Reset during WB of group 7.
    last_addr = 9'd20; start = 1'b1;
    tick(); start = 1'b0;
    cyc = 0;
    while (!(we && wr_addr == 9'd7) && cyc < 200) begin
      tick();
      cyc++;
    end
    check_val("rst_reach_wb7", 128'(cyc < 200), 1);
    rst_n = 1'b0;
    tick();
    check_val("midrst_out_a", {rd_addr, beta_addr, busy, done, cur_ready, wr_addr, we,
                               spike_valid, spike_addr, spike_out}, '0);
    check_val("midrst_wdata", wr_data, '0);
    rst_n = 1'b1;
    bad_we = 1'b0; bad_done = 1'b0;
    repeat (10) begin
      tick();
      if (we) bad_we = 1'b1;
      if (done) bad_done = 1'b1;
    end
    check_val("midrst_no_we", bad_we, 0);
    check_val("midrst_no_done", bad_done, 0);

    last_addr = 9'd1; start = 1'b1;
    tick(); start = 1'b0;
    check_val("restart_rd_addr", {busy, rd_addr}, {1'b1, 9'd0});
    tick(); tick();
    check_val("restart_wb0", {we, wr_addr}, {1'b1, 9'd0});
    tick();
    check_val("restart_rd1", {rd_addr, we}, {9'd1, 1'b0});
    tick(); tick();
    check_val("restart_wb1", {we, wr_addr}, {1'b1, 9'd1});
    tick();
    check_val("restart_done", done, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
